// File: rtl/cpu_defs_pkg.sv
// Shared fetch-stage definitions: reset/exception vectors, sequencer states
// and the redirect-source encoding used by the PC sequencer.
package cpu_defs_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR   = 32'h0000_4180;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HOLD,
    ERR
  } fetch_state_e;

  // Ordered so that a lower encoding is a higher-priority source.
  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_EXC,
    SRC_ERET,
    SRC_BR,
    SRC_JMP
  } redir_src_e;

  typedef struct packed {
    logic       valid;
    redir_src_e src;
    logic [31:0] target;
  } redir_t;

endpackage

// File: rtl/redirect_sel.sv
// Priority encoder for PC redirects (exc > eret > branch > jump) with a
// word-alignment check on the selected target.
module redirect_sel
  import cpu_defs_pkg::*;
(
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic        br_req,
  input  logic        jmp_req,
  input  logic [31:0] exc_target,
  input  logic [31:0] eret_target,
  input  logic [31:0] br_target,
  input  logic [31:0] jmp_target,
  output redir_t      redir,
  output logic        misalign
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    redir    = '{valid: 1'b0, src: SRC_NONE, target: '0};
    misalign = 1'b0;
    if (exc_req) begin
      redir = '{valid: 1'b1, src: SRC_EXC, target: exc_target};
    end else if (eret_req) begin
      redir = '{valid: 1'b1, src: SRC_ERET, target: eret_target};
    end else if (br_req) begin
      redir = '{valid: 1'b1, src: SRC_BR, target: br_target};
    end else if (jmp_req) begin
      redir = '{valid: 1'b1, src: SRC_JMP, target: jmp_target};
    end
    misalign = redir.valid && (redir.target[1:0] != 2'b00);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage controller: owns pc_F, runs the imem req/ack handshake, and
// applies or parks redirects from CP0, branch and jump resolution.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = cpu_defs_pkg::RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = cpu_defs_pkg::EXC_VECTOR,
  parameter int unsigned TIMEOUT      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_D,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic [31:0] pc_F,
  output logic        fetch_valid,
  output logic        flush_D,
  output logic        adel_F,
  output logic        bus_err
);

  import cpu_defs_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [7:0]   wait_cnt_q, wait_cnt_d;
  logic         pend_valid_q, pend_valid_d;
  redir_src_e   pend_src_q, pend_src_d;
  logic [31:0]  pend_target_q, pend_target_d;
  logic         flush_q, flush_d;
  logic         adel_q, adel_d;
  logic         bus_err_q, bus_err_d;

  logic        eret_ok, br_ok, jmp_ok;
  logic        outstanding;
  logic [31:0] pc_plus4;
  redir_t      sel;
  logic        sel_misalign;

  assign eret_ok     = eret_req & ~stall_D;
  assign br_ok       = br_taken & ~stall_D;
  assign jmp_ok      = jmp & ~stall_D;
  assign outstanding = (wait_cnt_q != 8'd0);
  assign pc_plus4    = pc_q + 32'd4;

  // Live requests are merged with the parked one, so the winner is both the
  // redirect to apply on ack and the new pending value when no ack arrives.
  redirect_sel u_redirect_sel (
    .exc_req    (exc_req  | (pend_valid_q && pend_src_q == SRC_EXC)),
    .eret_req   (eret_ok  | (pend_valid_q && pend_src_q == SRC_ERET)),
    .br_req     (br_ok    | (pend_valid_q && pend_src_q == SRC_BR)),
    .jmp_req    (jmp_ok   | (pend_valid_q && pend_src_q == SRC_JMP)),
    .exc_target (EXC_VECTOR),
    .eret_target(eret_ok ? epc : pend_target_q),
    .br_target  (br_ok ? br_target : pend_target_q),
    .jmp_target (jmp_ok ? jmp_target : pend_target_q),
    .redir      (sel),
    .misalign   (sel_misalign)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    wait_cnt_d    = wait_cnt_q;
    pend_valid_d  = pend_valid_q;
    pend_src_d    = pend_src_q;
    pend_target_d = pend_target_q;
    flush_d       = 1'b0;
    adel_d        = 1'b0;
    bus_err_d     = 1'b0;
    imem_req      = 1'b0;
    fetch_valid   = 1'b0;

    case (state_q)
      BOOT: state_d = FETCH;

      ERR: begin
        pc_d         = EXC_VECTOR;
        pend_valid_d = 1'b0;
        wait_cnt_d   = 8'd0;
        bus_err_d    = 1'b1;
        state_d      = FETCH;
      end

      FETCH, HOLD: begin
        if (state_q == HOLD || (stall_D && !outstanding)) begin
          // Parked: exceptions land immediately, everything else waits in pending.
          state_d = stall_D ? HOLD : FETCH;
          if (exc_req) begin
            pc_d         = EXC_VECTOR;
            flush_d      = 1'b1;
            pend_valid_d = 1'b0;
          end else if (sel.valid) begin
            pend_valid_d  = 1'b1;
            pend_src_d    = sel.src;
            pend_target_d = sel.target;
          end
        end else begin
          imem_req = ~stall_D;
          if (imem_req && imem_ack) begin
            wait_cnt_d = 8'd0;
            if (sel.valid) begin
              pc_d         = {sel.target[31:2], 2'b00};
              flush_d      = 1'b1;
              adel_d       = sel_misalign;
              pend_valid_d = 1'b0;
            end else begin
              pc_d        = pc_plus4;
              fetch_valid = 1'b1;
            end
          end else begin
            if (sel.valid) begin
              pend_valid_d  = 1'b1;
              pend_src_d    = sel.src;
              pend_target_d = sel.target;
            end
            if (imem_req) begin
              if (wait_cnt_q == 8'(TIMEOUT - 1)) begin
                state_d = ERR;
              end else begin
                wait_cnt_d = wait_cnt_q + 8'd1;
              end
            end
          end
        end
      end

      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      wait_cnt_q    <= 8'd0;
      pend_valid_q  <= 1'b0;
      pend_src_q    <= SRC_NONE;
      pend_target_q <= 32'd0;
      flush_q       <= 1'b0;
      adel_q        <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      pc_q          <= pc_d;
      wait_cnt_q    <= wait_cnt_d;
      pend_valid_q  <= pend_valid_d;
      pend_src_q    <= pend_src_d;
      pend_target_q <= pend_target_d;
      flush_q       <= flush_d;
      adel_q        <= adel_d;
      bus_err_q     <= bus_err_d;
    end
  end

  assign pc_F      = pc_q;
  assign imem_addr = pc_q;
  assign flush_D   = flush_q;
  assign adel_F    = adel_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized scoreboard bench for pc_sequencer: a behavioural fetch model
// predicts observable events, a negedge monitor compares what the DUT shows.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC  = 32'h0000_3000;
  localparam logic [31:0] EXC_PC  = 32'h0000_4180;
  localparam int          TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_D = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        jmp = 1'b0;
  logic [31:0] jmp_target = '0;
  logic        exc_req = 1'b0;
  logic        eret_req = 1'b0;
  logic [31:0] epc = '0;
  logic        ack_en = 1'b0;
  logic        ack_raw = 1'b0;
  logic        imem_req, imem_ack, fetch_valid, flush_D, adel_F, bus_err;
  logic [31:0] imem_addr, pc_F;

  always #5 clk = ~clk;

  // Memory responds only to a live request, except for a deliberate stray ack.
  assign imem_ack = ack_en & (imem_req | ack_raw);

  pc_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall_D    (stall_D),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .exc_req    (exc_req),
    .eret_req   (eret_req),
    .epc        (epc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .pc_F       (pc_F),
    .fetch_valid(fetch_valid),
    .flush_D    (flush_D),
    .adel_F     (adel_F),
    .bus_err    (bus_err)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        req;
    logic        fv;
    logic        fl;
    logic        ad;
    logic        be;
  } obs_t;

  obs_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks what the fetch unit is doing, not how it is built.
  typedef enum {M_BOOTING, M_RUNNING, M_PARKED, M_FAULTED} mmode_e;
  mmode_e      m_mode;
  logic [31:0] m_pc;
  int          m_wait;
  bit          m_pend;
  int          m_prank;
  logic [31:0] m_ptgt;
  bit          m_fl, m_ad, m_be;

  task automatic model_reset();
    m_mode = M_BOOTING;
    m_pc   = RST_PC;
    m_wait = 0;
    m_pend = 0;
    m_prank = 0;
    m_ptgt = '0;
    m_fl = 0; m_ad = 0; m_be = 0;
  endtask

  task automatic model_step();
    bit          req = 0, fv = 0, nfl = 0, nad = 0, nbe = 0, ack;
    bit          live[4];
    logic [31:0] tgt[4];
    logic [31:0] cur_pc = m_pc;
    int          mr = -1;
    logic [31:0] mt = '0;
    live[0] = exc_req;
    live[1] = eret_req && !stall_D;
    live[2] = br_taken && !stall_D;
    live[3] = jmp && !stall_D;
    tgt = '{EXC_PC, epc, br_target, jmp_target};
    for (int r = 3; r >= 0; r--) if (live[r]) mr = r;
    if (mr >= 0) mt = tgt[mr];
    if (m_pend && (mr < 0 || m_prank < mr)) begin
      mr = m_prank;
      mt = m_ptgt;
    end
    case (m_mode)
      M_BOOTING: m_mode = M_RUNNING;
      M_FAULTED: begin
        m_pc = EXC_PC; m_pend = 0; m_wait = 0; nbe = 1;
        m_mode = M_RUNNING;
      end
      default: begin
        if (m_mode == M_PARKED || (stall_D && m_wait == 0)) begin
          if (exc_req) begin
            m_pc = EXC_PC; nfl = 1; m_pend = 0;
          end else if (mr >= 0) begin
            m_pend = 1; m_prank = mr; m_ptgt = mt;
          end
          m_mode = stall_D ? M_PARKED : M_RUNNING;
        end else begin
          req = !stall_D;
          ack = ack_en && req;
          if (ack) begin
            m_wait = 0;
            if (mr >= 0) begin
              m_pc = {mt[31:2], 2'b00}; nfl = 1; nad = (mt[1:0] != 2'b00); m_pend = 0;
            end else begin
              fv = 1; m_pc = m_pc + 32'd4;
            end
          end else begin
            if (mr >= 0) begin
              m_pend = 1; m_prank = mr; m_ptgt = mt;
            end
            if (req) begin
              if (m_wait == TIMEOUT - 1) m_mode = M_FAULTED;
              else m_wait++;
            end
          end
        end
      end
    endcase
    if (fv || m_fl || m_ad || m_be) sb.push_back('{cur_pc, req, fv, m_fl, m_ad, m_be});
    m_fl = nfl; m_ad = nad; m_be = nbe;
  endtask

  // kind: 0 none, 1 exc, 2 eret, 3 branch, 4 jump; t is that source's target.
  task automatic cyc(input bit st, input bit ak, input int kind, input logic [31:0] t);
    @(posedge clk); #1;
    stall_D = st; ack_en = ak; ack_raw = 1'b0;
    exc_req = (kind == 1); eret_req = (kind == 2); epc = t;
    br_taken = (kind == 3); br_target = t;
    jmp = (kind == 4); jmp_target = t;
    model_step();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    stall_D = 0; exc_req = 0; eret_req = 0; br_taken = 0; jmp = 0;
    ack_en = 1'b1; ack_raw = 1'b1;
    model_reset();
    @(negedge clk);
    check("rst_pc", pc_F, RST_PC);
    check("rst_req", imem_req, 0);
    check("rst_fv", fetch_valid, 0);
    check("rst_flush", flush_D, 0);
    check("rst_adel", adel_F, 0);
    check("rst_buserr", bus_err, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_step();
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t = $urandom;
    if ($urandom_range(0, 1) == 0) t[1:0] = 2'b00;
    return t;
  endfunction

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!reset) begin
        obs_t got;
        got = '{pc_F, imem_req, fetch_valid, flush_D, adel_F, bus_err};
        check("addr_is_pc", imem_addr, pc_F);
        if (fetch_valid || flush_D || adel_F || bus_err) begin
          if (sb.size() == 0) check("unexpected_event", got, '0);
          else check("sb_event", got, sb.pop_front());
        end
      end
    end
  end

  initial begin : stimulus
    int drought = 0;
    model_reset();
    do_reset();

    // Zero-wait stream, then a branch in the same cycle as the ack for 0x3008.
    cyc(0, 1, 0, 0); @(negedge clk); check("seq_pc0", pc_F, 32'h3000); check("seq_fv0", fetch_valid, 1);
    cyc(0, 1, 0, 0); @(negedge clk); check("seq_pc1", pc_F, 32'h3004);
    cyc(0, 1, 3, 32'h3100); @(negedge clk); check("br_kill", fetch_valid, 0);
    cyc(0, 1, 0, 0); @(negedge clk); check("br_pc", pc_F, 32'h3100); check("br_flush", flush_D, 1);
    cyc(0, 1, 0, 0); @(negedge clk); check("br_flush_once", flush_D, 0);

    // Delayed ack with a jump parked during the wait.
    cyc(0, 0, 4, 32'h3200);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0); @(negedge clk); check("pend_kill", fetch_valid, 0);
    cyc(0, 1, 0, 0); @(negedge clk); check("pend_pc", pc_F, 32'h3200); check("pend_flush", flush_D, 1);
    check("pend_no_timeout", bus_err, 0);

    // Four stall cycles at 0x3010 with an exception in the third.
    cyc(0, 1, 4, 32'h3010);
    cyc(1, 1, 0, 0); @(negedge clk); check("stall_pc", pc_F, 32'h3010); check("stall_req0", imem_req, 0);
    cyc(1, 1, 0, 0); @(negedge clk); check("stall_req1", imem_req, 0);
    cyc(1, 1, 1, 0); @(negedge clk); check("stall_req2", imem_req, 0);
    cyc(1, 1, 0, 0); @(negedge clk); check("hold_exc_pc", pc_F, EXC_PC); check("hold_exc_flush", flush_D, 1);
    check("stall_req3", imem_req, 0);
    cyc(0, 1, 0, 0); @(negedge clk); check("unstall_req", imem_req, 0);
    cyc(0, 1, 0, 0); @(negedge clk); check("resume_addr", imem_addr, EXC_PC); check("resume_fv", fetch_valid, 1);

    // Misaligned ERET target.
    cyc(0, 1, 2, 32'h3022);
    cyc(0, 1, 0, 0); @(negedge clk); check("eret_pc", pc_F, 32'h3020); check("eret_adel", adel_F, 1);

    // Fetch timeout after TIMEOUT unacknowledged cycles.
    repeat (TIMEOUT - 1) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0); @(negedge clk); check("to_not_early", bus_err, 0); check("to_last_req", imem_req, 1);
    cyc(0, 0, 0, 0); @(negedge clk); check("err_req", imem_req, 0);
    cyc(0, 1, 4, 32'hFFFF_FFFC); @(negedge clk); check("err_pc", pc_F, EXC_PC); check("err_buserr", bus_err, 1);

    // Sequential wrap at the top of the address space.
    cyc(0, 1, 0, 0); @(negedge clk); check("wrap_from", pc_F, 32'hFFFF_FFFC);
    cyc(0, 1, 0, 0); @(negedge clk); check("wrap_to", pc_F, 32'h0000_0000);

    // Reset while a fetch is outstanding, with a stray ack during boot.
    cyc(0, 0, 0, 0);
    do_reset();
    cyc(0, 1, 0, 0); @(negedge clk); check("reboot_pc", pc_F, RST_PC); check("reboot_fv", fetch_valid, 1);

    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if (drought > 0) drought--;
      else if ($urandom_range(0, 299) == 0) drought = 12;
      stall_D    = ($urandom_range(0, 4) == 0);
      ack_en     = (drought == 0) && ($urandom_range(0, 9) < 7);
      ack_raw    = 1'b0;
      exc_req    = ($urandom_range(0, 24) == 0);
      eret_req   = ($urandom_range(0, 11) == 0);
      br_taken   = ($urandom_range(0, 7) == 0);
      jmp        = ($urandom_range(0, 7) == 0);
      epc        = rand_target();
      br_target  = rand_target();
      jmp_target = rand_target();
      model_step();
    end

    repeat (5) cyc(0, 1, 0, 0);
    @(negedge clk); #1;
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
